// File: rtl/punc_debug_dump.sv
`default_nettype none
// ============================================================================
// Module      : punc_debug_dump
// Description : Debug-side initiator for the PUnC datapath debug read ports.
//               On start, walks R0..R7, then the PC, then a memory window
//               [mem_base, mem_base + mem_count), driving the debug address of
//               each item, capturing the returned data and emitting it as a
//               tagged word on a valid/ready stream.
// Ports       : clk, rst (sync, active-low)
//               start, mem_base, mem_count      - dump request
//               busy, done                      - dump status
//               mem_debug_addr, rf_debug_addr   - debug port addresses
//               mem_debug_data, rf_debug_data,
//               pc_debug_data                   - debug port read data
//               out_valid, out_ready, out_data,
//               out_tag, out_index, out_last    - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module punc_debug_dump #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] mem_base,
    input  logic [CNT_W-1:0]  mem_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_debug_addr,
    output logic [2:0]        rf_debug_addr,
    input  logic [15:0]       mem_debug_data,
    input  logic [15:0]       rf_debug_data,
    input  logic [15:0]       pc_debug_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [1:0]        out_tag,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // Phase encoding doubles as the emitted out_tag value.
    typedef enum logic [1:0] {
        PH_REG = 2'd0,
        PH_PC  = 2'd1,
        PH_MEM = 2'd2
    } phase_t;

    state_t            state;
    state_t            state_nx;
    phase_t            phase;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic              handshake;
    logic              final_item;

    assign handshake = out_valid && out_ready;

    // The current item is the last of the dump: the PC when no memory words
    // were requested, otherwise the memory word that brings remaining to 0.
    assign final_item = ((phase == PH_PC)  && (remaining == '0)) ||
                        ((phase == PH_MEM) && (remaining == CNT_W'(1)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                busy     = 1'b1;
                state_nx = S_CAP;
            end
            S_CAP: begin
                busy     = 1'b1;
                state_nx = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = final_item ? S_FIN : S_ADDR;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Walk pointers, debug addresses and captured output word.
    // rf_debug_addr doubles as the register index. The debug addresses are
    // loaded on the transition into ADDR so they are stable for the whole
    // ADDR/CAP pair, and otherwise hold their last driven value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase          <= PH_REG;
            cur_addr       <= '0;
            remaining      <= '0;
            mem_debug_addr <= '0;
            rf_debug_addr  <= 3'd0;
            out_data       <= 16'd0;
            out_tag        <= 2'd0;
            out_index      <= '0;
            out_last       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_debug_addr <= '0;
                    rf_debug_addr  <= 3'd0;
                    if (start) begin
                        cur_addr  <= mem_base;
                        remaining <= mem_count;
                        phase     <= PH_REG;
                    end
                end
                S_CAP: begin
                    out_tag  <= phase;
                    out_last <= final_item;
                    case (phase)
                        PH_REG: begin
                            out_data  <= rf_debug_data;
                            out_index <= {{(ADDR_W-3){1'b0}}, rf_debug_addr};
                        end
                        PH_PC: begin
                            out_data  <= pc_debug_data;
                            out_index <= '0;
                        end
                        default: begin
                            out_data  <= mem_debug_data;
                            out_index <= cur_addr;
                        end
                    endcase
                end
                S_SEND: begin
                    if (handshake) begin
                        case (phase)
                            PH_REG: begin
                                if (rf_debug_addr == 3'd7) begin
                                    phase <= PH_PC;
                                end else begin
                                    rf_debug_addr <= rf_debug_addr + 3'd1;
                                end
                            end
                            PH_PC: begin
                                if (remaining != '0) begin
                                    phase          <= PH_MEM;
                                    mem_debug_addr <= cur_addr;
                                end
                            end
                            default: begin
                                // Address arithmetic wraps modulo 2^ADDR_W.
                                remaining <= remaining - CNT_W'(1);
                                cur_addr  <= cur_addr + ADDR_W'(1);
                                if (remaining != CNT_W'(1)) begin
                                    mem_debug_addr <= cur_addr + ADDR_W'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
